// File: rtl/z80_clkgen.sv
// Multi-channel programmable clock divider gated by a qualified PLL lock.
// Outputs are registered: a start request or a lock loss is visible one clkin edge later.
module z80_clkgen #(
    parameter int NCH       = 2,
    parameter int DIVW      = 8,
    parameter int LOCK_WAIT = 16
) (
    input  logic                  clkin,
    input  logic                  reset,
    input  logic                  lock,
    input  logic [NCH*DIVW-1:0]   div,
    input  logic [NCH-1:0]        div_load,
    input  logic [NCH-1:0]        run,
    input  logic [NCH-1:0]        step,
    output logic [NCH-1:0]        clkout,
    output logic [NCH-1:0]        tick,
    output logic [NCH-1:0]        busy,
    output logic                  ready
);

    localparam int LW = $clog2(LOCK_WAIT + 1);

    typedef enum logic {IDLE, ACTIVE} st_t;

    logic [LW-1:0] lock_cnt;
    logic          run_ok;

    // Channels may only advance while ready holds and lock is still present;
    // this drops every channel on the same edge that ready falls.
    assign run_ok = ready & lock;

    always_ff @(posedge clkin or posedge reset) begin
        if (reset) begin
            lock_cnt <= '0;
            ready    <= 1'b0;
        end else if (!lock) begin
            lock_cnt <= '0;
            ready    <= 1'b0;
        end else begin
            if (lock_cnt != LW'(LOCK_WAIT))
                lock_cnt <= lock_cnt + 1'b1;
            ready <= (lock_cnt >= LW'(LOCK_WAIT - 1));
        end
    end

    for (genvar i = 0; i < NCH; i++) begin : g_ch
        st_t             state;
        logic [DIVW-1:0] cnt;
        logic [DIVW-1:0] active_div;
        logic [DIVW-1:0] pend_div;
        logic            pend_flag;
        logic            clk_r;
        logic            tick_r;
        logic [DIVW-1:0] div_i;
        logic [DIVW-1:0] next_div;
        logic [DIVW-1:0] per;
        logic [DIVW:0]   half;
        logic [DIVW:0]   cnt_nx;
        logic            last;

        assign div_i    = div[i*DIVW +: DIVW];
        // A load presented on the wrap cycle wins over an older pending value.
        assign next_div = div_load[i] ? div_i : (pend_flag ? pend_div : active_div);
        assign per      = (active_div < DIVW'(2)) ? DIVW'(2) : active_div;
        assign half     = ({1'b0, per} + 1'b1) >> 1;
        assign cnt_nx   = {1'b0, cnt} + 1'b1;
        assign last     = (cnt == per - 1'b1);

        always_ff @(posedge clkin or posedge reset) begin
            if (reset) begin
                state      <= IDLE;
                cnt        <= '0;
                clk_r      <= 1'b0;
                tick_r     <= 1'b0;
                active_div <= DIVW'(2);
                pend_div   <= DIVW'(2);
                pend_flag  <= 1'b0;
            end else begin
                tick_r <= 1'b0;
                if (div_load[i]) begin
                    pend_div  <= div_i;
                    pend_flag <= 1'b1;
                end
                if (!run_ok) begin
                    state <= IDLE;
                    cnt   <= '0;
                    clk_r <= 1'b0;
                end else begin
                    case (state)
                        IDLE: begin
                            active_div <= next_div;
                            pend_flag  <= 1'b0;
                            if (run[i] || step[i]) begin
                                state  <= ACTIVE;
                                cnt    <= '0;
                                clk_r  <= 1'b1;
                                tick_r <= 1'b1;
                            end
                        end
                        ACTIVE: begin
                            if (last) begin
                                active_div <= next_div;
                                pend_flag  <= 1'b0;
                                cnt        <= '0;
                                if (run[i]) begin
                                    clk_r  <= 1'b1;
                                    tick_r <= 1'b1;
                                end else begin
                                    state <= IDLE;
                                    clk_r <= 1'b0;
                                end
                            end else begin
                                cnt   <= cnt_nx[DIVW-1:0];
                                clk_r <= (cnt_nx < half);
                            end
                        end
                        default: state <= IDLE;
                    endcase
                end
            end
        end

        assign clkout[i] = clk_r;
        assign tick[i]   = tick_r;
        assign busy[i]   = (state == ACTIVE);
    end

endmodule

// File: tb/tb_z80_clkgen.sv
// Bench for z80_clkgen: directed stimulus pushes per-cycle expectations, a negedge monitor checks them.
module tb_z80_clkgen;

    logic        clkin = 1'b0;
    logic        reset = 1'b1;
    logic        lock  = 1'b0;
    logic [15:0] div   = '0;
    logic [1:0]  div_load = '0;
    logic [1:0]  run   = '0;
    logic [1:0]  step  = '0;
    logic [1:0]  clkout, tick, busy;
    logic        ready;

    int cyc = 0;
    int n_checks = 0;
    int n_fail = 0;

    typedef struct {
        int         cyc;
        int         ch;      // -1 selects ready
        logic [2:0] v;       // {clkout, tick, busy} or ready in bit 0
    } exp_t;

    exp_t sb[$];

    z80_clkgen #(.NCH(2), .DIVW(8), .LOCK_WAIT(16)) dut (
        .clkin(clkin), .reset(reset), .lock(lock), .div(div),
        .div_load(div_load), .run(run), .step(step),
        .clkout(clkout), .tick(tick), .busy(busy), .ready(ready)
    );

    always #5 clkin = ~clkin;
    always @(posedge clkin) cyc <= cyc + 1;

    task automatic push(input int c, input int ch, input logic [2:0] v);
        exp_t e;
        e.cyc = c; e.ch = ch; e.v = v;
        sb.push_back(e);
    endtask

    task automatic exp_seq(input int ch, input int start, input string c, input string t, input string b);
        for (int k = 0; k < c.len(); k++)
            push(start + k, ch, {c[k] == "1", t[k] == "1", b[k] == "1"});
    endtask

    task automatic waitn(input int n);
        repeat (n) @(negedge clkin);
    endtask

    // Monitor: checks every expectation due at this cycle, flags any that were missed.
    always @(negedge clkin) begin
        for (int i = sb.size() - 1; i >= 0; i--) begin
            if (sb[i].cyc < cyc) begin
                n_checks++;
                n_fail++;
                $display("FAIL stale ch%0d cyc%0d: expectation never checked (now cyc%0d)", sb[i].ch, sb[i].cyc, cyc);
                sb.delete(i);
            end else if (sb[i].cyc == cyc) begin
                n_checks++;
                if (sb[i].ch < 0) begin
                    if (ready !== sb[i].v[0]) begin
                        n_fail++;
                        $display("FAIL ready cyc%0d: got %b want %b", cyc, ready, sb[i].v[0]);
                    end
                end else if ({clkout[sb[i].ch], tick[sb[i].ch], busy[sb[i].ch]} !== sb[i].v) begin
                    n_fail++;
                    $display("FAIL ch%0d cyc%0d {clkout,tick,busy}: got %b%b%b want %b",
                             sb[i].ch, cyc, clkout[sb[i].ch], tick[sb[i].ch], busy[sb[i].ch], sb[i].v);
                end
                sb.delete(i);
            end
        end
    end

    initial begin
        int c0, c1, c;
        string ch1_clk, ch1_tck, ch1_bsy;

        // Reset state
        waitn(1);
        push(cyc + 1, -1, 3'b000);
        push(cyc + 1, 0, 3'b000);
        push(cyc + 1, 1, 3'b000);
        waitn(1);
        reset = 1'b0;

        // Lock qualification, interrupted after 9 good cycles
        lock = 1'b1;
        c0 = cyc;
        push(c0 + 9, -1, 3'b000);
        waitn(9);
        lock = 1'b0;
        waitn(1);
        lock = 1'b1;
        run[0] = 1'b1;
        c1 = cyc;
        push(c1 + 15, -1, 3'b000);
        push(c1 + 16, -1, 3'b001);
        push(c1 + 15, 0, 3'b000);
        push(c1 + 16, 0, 3'b000);
        waitn(16);

        // Channel traffic: ch0 directed sequence, ch1 free-running at div=3
        c = cyc;
        exp_seq(0, c + 1,
            {"11001100", "11100", "111000", "0011000", "10101010", "11", "0"},
            {"10001000", "10000", "100000", "0010000", "10101010", "10", "0"},
            {"11111111", "11111", "111111", "0011100", "11111111", "11", "0"});
        ch1_clk = ""; ch1_tck = ""; ch1_bsy = "";
        for (int k = 0; k < 12; k++) begin
            ch1_clk = {ch1_clk, "110"};
            ch1_tck = {ch1_tck, "100"};
            ch1_bsy = {ch1_bsy, "111"};
        end
        exp_seq(1, c + 1, {ch1_clk, "0"}, {ch1_tck, "0"}, {ch1_bsy, "0"});
        push(c + 20, -1, 3'b001);
        push(c + 37, -1, 3'b000);

        div[15:8] = 8'd3;
        div[7:0]  = 8'd4;
        div_load  = 2'b11;
        run[1]    = 1'b1;
        waitn(1);                       // c+1
        div_load  = 2'b00;
        waitn(7);                       // c+8: last cycle of period, load lands on the wrap
        div[7:0]  = 8'd5;
        div_load[0] = 1'b1;
        waitn(1);                       // c+9
        div_load[0] = 1'b0;
        waitn(1);                       // c+10: mid-period load is deferred
        div[7:0]  = 8'd6;
        div_load[0] = 1'b1;
        waitn(1);                       // c+11
        div_load[0] = 1'b0;
        waitn(4);                       // c+15: run drops at cnt=1, period must finish
        run[0]    = 1'b0;
        waitn(5);                       // c+20: idle, load div=3
        div[7:0]  = 8'd3;
        div_load[0] = 1'b1;
        waitn(1);                       // c+21
        div_load[0] = 1'b0;
        step[0]   = 1'b1;
        waitn(1);                       // c+22
        step[0]   = 1'b0;
        waitn(1);                       // c+23: step while busy is ignored
        step[0]   = 1'b1;
        waitn(1);                       // c+24
        step[0]   = 1'b0;
        waitn(2);                       // c+26: div=0 behaves as 2
        div[7:0]  = 8'd0;
        div_load[0] = 1'b1;
        run[0]    = 1'b1;
        waitn(1);                       // c+27
        div_load[0] = 1'b0;
        waitn(3);                       // c+30: div=1 behaves as 2
        div[7:0]  = 8'd1;
        div_load[0] = 1'b1;
        waitn(1);                       // c+31
        div_load[0] = 1'b0;
        waitn(3);                       // c+34
        div[7:0]  = 8'd8;
        div_load[0] = 1'b1;
        waitn(1);                       // c+35
        div_load[0] = 1'b0;
        waitn(1);                       // c+36: lock lost mid-period
        lock      = 1'b0;
        waitn(3);

        if (sb.size() != 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL leftover: %0d expectations unchecked, want 0", sb.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/z80_clkgen.md
Z80_CLKGEN -- requirements
Module: z80_clkgen

Interface
REQ-001 SHALL provide parameter NCH, default 2, number of independent clock channels.
REQ-002 SHALL provide parameter DIVW, default 8, width of each channel's divide ratio.
REQ-003 SHALL provide parameter LOCK_WAIT, default 16, consecutive clkin cycles of lock high required before ready.
REQ-004 SHALL have port clkin, input, 1, sole clock; all logic on its rising edge.
REQ-005 SHALL have port reset, input, 1, asynchronous active-high reset.
REQ-006 SHALL have port lock, input, 1, PLL lock indication, already synchronous to clkin.
REQ-007 SHALL have port div, input, NCH*DIVW, per-channel period in clkin cycles; channel i uses bits [i*DIVW +: DIVW].
REQ-008 SHALL have port div_load, input, NCH, per-channel one-cycle request to capture div.
REQ-009 SHALL have port run, input, NCH, per-channel free-run enable (level).
REQ-010 SHALL have port step, input, NCH, per-channel single-period request (pulse).
REQ-011 SHALL have port clkout, output, NCH, registered divided clocks.
REQ-012 SHALL have port tick, output, NCH, one-cycle pulse coincident with each clkout 0->1.
REQ-013 SHALL have port busy, output, NCH, high while channel emits a period.
REQ-014 SHALL have port ready, output, 1, lock qualified for LOCK_WAIT cycles.

Function
REQ-015 Each channel SHALL hold active period P = max(active_div, 2); active_div values 0 and 1 SHALL behave as 2.
REQ-016 Each channel SHALL count cnt 0..P-1 while busy; clkout high for cnt < ceil(P/2), low otherwise (P=5: 3 high, 2 low).
REQ-017 Channel states SHALL be IDLE (cnt=0, clkout=0, busy=0) and ACTIVE (busy=1).
REQ-018 IDLE->ACTIVE SHALL occur when ready=1 and (run=1 or step=1); clkout SHALL rise and tick pulse on the next edge (latency 1 cycle).
REQ-019 At cnt=P-1, ACTIVE SHALL continue with cnt=0 if run=1, else return to IDLE; a period is never truncated by run falling.
REQ-020 step while ACTIVE SHALL be ignored (not queued); step with run=1 SHALL have no extra effect.
REQ-021 div_load SHALL capture div into a pending register and set a pending flag; a second div_load before application SHALL overwrite pending.
REQ-022 Pending SHALL transfer to active_div at period wrap (cnt=P-1) or immediately while IDLE; the new P SHALL govern the very next period.
REQ-023 div_load in the same cycle as a wrap SHALL apply the newly presented div value at that wrap.
REQ-024 A lock-qualify counter SHALL count consecutive lock=1 cycles, saturating; ready SHALL assert on the cycle the count reaches LOCK_WAIT.
REQ-025 lock=0 SHALL clear the counter and deassert ready on the next edge; while ready=0 all channels SHALL be forced IDLE (clkout=0, tick=0, busy=0) immediately, truncating any period.
REQ-026 Pending div SHALL survive ready loss; active_div SHALL be retained.
REQ-027 Channels SHALL be fully independent except for shared ready.

Reset
REQ-028 reset SHALL asynchronously force clkout=0, tick=0, busy=0, ready=0, lock counter=0, all cnt=0, pending flags=0.
REQ-029 reset SHALL load active_div and pending register of every channel with 2.
REQ-030 Deassertion of reset SHALL require a full LOCK_WAIT qualification before any channel starts.

Verification
REQ-031 lock=1 steady after reset, LOCK_WAIT=16 -> ready rises exactly 16 cycles after first lock-high edge; toggling lock low at cycle 10 restarts the count.
REQ-032 ch0 div=4 loaded, run=1 -> clkout 1,1,0,0 repeating, tick every 4 cycles; div=5 -> 1,1,1,0,0.
REQ-033 ch0 running div=4, div_load with div=6 mid-period -> current period completes at 4 cycles, next period 6 cycles (3 high, 3 low).
REQ-034 run=0, step pulse, div=3 -> exactly one period 1,1,0, busy high 3 cycles; second step during busy -> no additional period.
REQ-035 run falls at cnt=1 of div=8 -> 8-cycle period completes then IDLE; lock falls mid-period -> clkout 0 and busy 0 on next edge.
REQ-036 div=0 and div=1 loaded -> both produce P=2 (1,0 pattern); ch1 with div=3 runs concurrently unaffected by ch0 changes.
